// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
//   state_t       transmitter FSM state encoding
//   OVS_DEF       default Tick pulses per bit
//   NBITS_MIN/MAX legal data-bit range
//   BAUD_9600_50M baud divider for 9600 baud at 50 MHz
//   eff_nbits()   maps NBits to the width actually sent
package uart_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
    localparam int OVS_DEF = 16;
    localparam int NBITS_MIN = 5;
    localparam int NBITS_MAX = 8;
    localparam logic [15:0] BAUD_9600_50M = 16'd325;
    function automatic logic [3:0] eff_nbits(input logic [3:0] n);
        return (n >= 4'(NBITS_MIN) && n <= 4'(NBITS_MAX)) ? n : 4'(NBITS_MAX);
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with registered full/empty/count.
//   Clk, Rst       clock, synchronous active-high reset
//   push, wdata    write request and data
//   pop            read request (ignored when empty)
//   rdata          head of queue (valid while !empty)
//   full, empty    registered status after each edge
//   overflow       one-cycle pulse when a push is dropped
module uart_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_nxt;
    logic do_wr, do_rd;
    assign do_rd = pop && !empty;
    // a full FIFO still accepts a write when a pop frees the slot this cycle
    assign do_wr = push && (!full || do_rd);
    assign count_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    assign rdata = mem[rd_ptr];
    always_ff @(posedge Clk) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count    <= count_nxt;
            full     <= count_nxt == (AW+1)'(DEPTH);
            empty    <= count_nxt == '0;
            overflow <= push && !do_wr;
        end
    end
endmodule

// File: rtl/uart_tick_tx_fifo.sv
// uart_tick_tx_fifo: buffered UART transmitter paced by a 16x oversampling Tick.
//   Clk, Rst        clock, synchronous active-high reset
//   Tick            one-cycle pulse at OVS x baud
//   TxEn            allows new frames to start
//   NBits           data bits per frame (5..8, else 8), sampled at frame start
//   WrEn, WrData    FIFO push
//   Full, Empty     FIFO status; Overflow pulses on a dropped write
//   Tx              serial line, idle high
//   TxBusy          frame in progress; TxDone pulses as the stop bit ends
module uart_tick_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int OVS    = OVS_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Tick,
    input  logic              TxEn,
    input  logic [3:0]        NBits,
    input  logic              WrEn,
    input  logic [DATA_W-1:0] WrData,
    output logic              Full,
    output logic              Empty,
    output logic              Overflow,
    output logic              Tx,
    output logic              TxBusy,
    output logic              TxDone
);
    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    state_t state, state_nxt;
    logic [TW-1:0] tick_cnt;
    logic [BW-1:0] bit_cnt, nb_last;
    logic [DATA_W-1:0] shift, head;
    logic pop, bit_end;
    assign pop = (state == IDLE) && TxEn && !Empty;
    assign bit_end = Tick && (tick_cnt == TW'(OVS - 1));
    uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .push    (WrEn),
        .pop     (pop),
        .wdata   (WrData),
        .rdata   (head),
        .full    (Full),
        .empty   (Empty),
        .overflow(Overflow)
    );
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = pop ? START : IDLE;
            START: state_nxt = bit_end ? DATA : START;
            DATA:  state_nxt = (bit_end && bit_cnt == nb_last) ? STOP : DATA;
            STOP:  state_nxt = bit_end ? IDLE : STOP;
        endcase
    end
    always_comb begin
        Tx = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
        TxBusy = state != IDLE;
    end
    // the pop clears the counters, so a Tick coinciding with the pop is not counted
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            nb_last  <= '0;
            shift    <= '0;
            TxDone   <= 1'b0;
        end else begin
            TxDone <= (state == STOP) && bit_end;
            if (pop) begin
                shift    <= head;
                nb_last  <= BW'(eff_nbits(NBits) - 4'd1);
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state != IDLE && Tick) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
                if (state == DATA && bit_end) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tick_tx_fifo.sv
// tb_uart_tick_tx_fifo: directed/random bench with a tick-counting frame decoder as reference.
module tb_uart_tick_tx_fifo;
    localparam int TP = 4;
    localparam int FRAME_MAX = 12 * 16 * TP + 50;
    logic Clk, Rst, Tick, TxEn, WrEn;
    logic [3:0] NBits;
    logic [7:0] WrData;
    logic Full, Empty, Overflow, Tx, TxBusy, TxDone;

    uart_tick_tx_fifo dut (
        .Clk(Clk), .Rst(Rst), .Tick(Tick), .TxEn(TxEn), .NBits(NBits),
        .WrEn(WrEn), .WrData(WrData), .Full(Full), .Empty(Empty),
        .Overflow(Overflow), .Tx(Tx), .TxBusy(TxBusy), .TxDone(TxDone)
    );

    typedef struct {logic [7:0] d; int n;} exp_t;
    exp_t exp_q[$];
    int tests = 0, fails = 0;
    int frames_seen = 0, stray = 0, max_gap = 0, gap_cnt = 0;
    int tc = 0, bad = 0, nb = 8;
    logic in_frame = 1'b0;
    logic [7:0] ed, got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int eff(input logic [3:0] n);
        return (n >= 5 && n <= 8) ? int'(n) : 8;
    endfunction

    function automatic logic ebit(input int k, input int n, input logic [7:0] d);
        return k == 0 ? 1'b0 : (k <= n ? d[k-1] : 1'b1);
    endfunction

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        Tick = 0;
        forever for (int i = 0; i < TP; i++) begin
            @(negedge Clk);
            Tick = (i == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // reference decoder: every bit lasts exactly 16 Ticks counted after the falling start edge
    always @(posedge Clk) begin
        int k;
        #1;
        if (Rst) begin
            in_frame = 1'b0;
            gap_cnt = 0;
        end else if (!in_frame) begin
            gap_cnt++;
            if (TxDone) stray++;
            if (!Tx) begin
                chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    ed = exp_q[0].d;
                    nb = exp_q[0].n;
                    void'(exp_q.pop_front());
                end else begin
                    ed = 8'h00;
                    nb = 8;
                end
                if (gap_cnt > max_gap) max_gap = gap_cnt;
                tc = 0;
                bad = TxBusy ? 0 : 1;
                got = 8'h00;
                in_frame = 1'b1;
            end
        end else begin
            if (Tick) tc++;
            k = tc / 16;
            if (tc == 16 * (nb + 2)) begin
                chk("frame_data", 32'(got), 32'(ed));
                chk("frame_timing", 32'(bad), 32'd0);
                chk("frame_done", {29'd0, TxDone, TxBusy, Tx}, 32'b101);
                frames_seen++;
                in_frame = 1'b0;
                gap_cnt = 0;
            end else begin
                if (Tx !== ebit(k, nb, ed)) bad++;
                if (TxBusy !== 1'b1 || TxDone !== 1'b0) bad++;
                if (k >= 1 && k <= nb && tc % 16 == 8) got[k-1] = Tx;
            end
        end
    end

    task automatic wr(input logic [7:0] d, input logic expect_it);
        exp_t e;
        e.n = eff(NBits);
        e.d = d & 8'((1 << e.n) - 1);
        WrEn = 1;
        WrData = d;
        if (expect_it) exp_q.push_back(e);
        @(negedge Clk);
        WrEn = 0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int target = frames_seen + n;
        for (int i = 0; i < n * FRAME_MAX && frames_seen < target; i++) @(negedge Clk);
        chk(tag, 32'(frames_seen >= target), 32'd1);
    endtask

    task automatic wait_busy(input string tag);
        for (int i = 0; i < 100 && !TxBusy; i++) @(negedge Clk);
        chk(tag, 32'(TxBusy), 32'd1);
    endtask

    task automatic quiet(input int cycles, input string tag);
        int b = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (Tx !== 1'b1 || TxBusy !== 1'b0) b++;
        end
        chk(tag, 32'(b), 32'd0);
    endtask

    initial begin
        int f0, b;
        Rst = 1; TxEn = 1; NBits = 4'd8; WrEn = 0; WrData = 8'h00;
        repeat (3) @(negedge Clk);
        chk("rst_tx", 32'(Tx), 32'd1);
        chk("rst_busy", 32'(TxBusy), 32'd0);
        chk("rst_done", 32'(TxDone), 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chk("rst_empty", 32'(Empty), 32'd1);
        chk("rst_full", 32'(Full), 32'd0);
        Rst = 0;

        b = 0;
        for (int i = 0; i < 200 * TP; i++) begin
            @(negedge Clk);
            if (Tx !== 1'b1 || Empty !== 1'b1 || TxBusy !== 1'b0) b++;
        end
        chk("idle_200_ticks", 32'(b), 32'd0);

        wr(8'h61, 1);
        wait_frames(1, "frame_61_timeout");
        chk("empty_after_61", 32'(Empty), 32'd1);
        @(negedge Clk);
        chk("done_single_pulse", 32'(TxDone), 32'd0);

        for (int i = 0; i < 10; i++) begin
            WrEn = 1;
            WrData = 8'(i);
            if (i < 9) exp_q.push_back('{8'(i), 8});
            @(negedge Clk);
            if (i == 8) chk("full_after_9", 32'(Full), 32'd1);
            if (i == 9) chk("overflow_pulse", 32'(Overflow), 32'd1);
        end
        WrEn = 0;
        @(negedge Clk);
        chk("overflow_one_cycle", 32'(Overflow), 32'd0);
        wait_frames(1, "burst_first_timeout");
        max_gap = 0;
        wait_frames(8, "burst_rest_timeout");
        chk("burst_gap", 32'(max_gap >= 1 && max_gap < TP), 32'd1);
        chk("burst_empty", 32'(Empty), 32'd1);

        NBits = 4'd5;
        wr(8'hFF, 1);
        wait_busy("nbits5_busy");
        NBits = 4'd8;
        wait_frames(1, "nbits5_timeout");
        NBits = 4'd0;
        wr(8'($urandom), 1);
        wait_frames(1, "nbits0_timeout");
        NBits = 4'd6;
        wr(8'($urandom), 1);
        wait_frames(1, "nbits6_timeout");
        NBits = 4'd15;
        wr(8'($urandom), 1);
        wait_frames(1, "nbits15_timeout");
        NBits = 4'd8;

        TxEn = 0;
        for (int i = 0; i < 3; i++) wr(8'($urandom), 1);
        quiet(3 * 16 * TP, "txen_low_quiet");
        chk("txen_low_queued", 32'(Empty), 32'd0);
        TxEn = 1;
        wait_frames(3, "txen_resume_timeout");
        wr(8'($urandom), 1);
        wr(8'($urandom), 1);
        wait_busy("txen_drop_busy");
        TxEn = 0;
        wait_frames(1, "txen_drop_finish");
        quiet(2 * 16 * TP, "txen_drop_no_start");
        chk("txen_drop_left", 32'(exp_q.size()), 32'd1);
        TxEn = 1;
        wait_frames(1, "txen_flush_timeout");

        wr(8'hA5, 1);
        wr(8'($urandom), 1);
        wr(8'($urandom), 1);
        for (int i = 0; i < FRAME_MAX && !(in_frame && tc >= 40); i++) @(negedge Clk);
        chk("reach_data", 32'(in_frame && tc >= 40), 32'd1);
        f0 = frames_seen;
        Rst = 1;
        @(negedge Clk);
        exp_q.delete();
        Rst = 0;
        chk("abort_tx", 32'(Tx), 32'd1);
        chk("abort_empty", 32'(Empty), 32'd1);
        chk("abort_busy", 32'(TxBusy), 32'd0);
        chk("abort_done", 32'(TxDone), 32'd0);
        quiet(16 * TP, "abort_quiet");
        chk("abort_no_frame", 32'(frames_seen), 32'(f0));
        wr(8'h3C, 1);
        wait_frames(1, "after_reset_timeout");

        repeat (4) @(negedge Clk);
        chk("no_stray_done", 32'(stray), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tick_tx_fifo.md
Name: uart_tick_tx_fifo

Overview:
- Buffered UART transmitter for the RS232 path. It is the counterpart to the receive side.
- Producers push bytes into an internal FIFO. The block serialises them on Tx as start / data / stop frames, paced by the shared 16x-oversampling Tick from the baud-rate generator.
- It sits beside the receiver in the top level. It lets status and echo logic queue several bytes without waiting on TxDone.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DATA_W, 8, FIFO and shift-register width; maximum frame data bits.
- OVS, 16, Tick pulses per bit period.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- Tick  in  1  one-Clk pulse at 16x baud, from the baud generator.
- TxEn  in  1  when low, no new frame starts; an in-flight frame completes.
- NBits  in  4  data bits per frame. Legal values 5..8; any other value is treated as 8. Sampled when a frame starts.
- WrEn  in  1  push WrData into the FIFO.
- WrData  in  DATA_W  byte to transmit, LSB sent first.
- Full  out  1  FIFO count == DEPTH.
- Empty  out  1  FIFO count == 0.
- Overflow  out  1  one-cycle pulse when a write is dropped.
- Tx  out  1  serial line, idle high.
- TxBusy  out  1  high from the pop cycle through the end of the stop bit.
- TxDone  out  1  one-cycle pulse on the cycle the stop bit ends.

Behaviour:
- Reset (Rst=1 at a Clk edge), values from the next edge:
  - Tx=1, TxBusy=0, TxDone=0, Overflow=0, Empty=1, Full=0.
  - FIFO pointers and count cleared; FSM in IDLE; tick and bit counters at 0.
  - A reset mid-frame aborts the frame. Tx returns high on the next edge and queued data is discarded.
- FIFO:
  - A write is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the write is dropped and Overflow pulses.
  - Full and Empty are registered and reflect count after the edge.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: Tx=1. If TxEn=1 and Empty=0, pop the head into the shift register, latch the effective NBits, clear counters and go to START. TxBusy=1 from the next edge.
  - START: Tx=0. Each Tick increments tick_cnt. On the Tick where tick_cnt==OVS-1, clear tick_cnt and go to DATA.
  - DATA: Tx = shift[0]. On the Tick ending each bit (tick_cnt==OVS-1), shift right and increment bit_cnt. When bit_cnt reaches NBits-1 at a bit end, go to STOP.
  - STOP: Tx=1. On the Tick where tick_cnt==OVS-1, pulse TxDone, drop TxBusy and go to IDLE.
- Bit timing:
  - Each bit lasts exactly OVS Tick pulses, counted from the first Tick after entering the state.
  - The start bit may therefore run up to one Tick period long. This is accepted.
- Back-to-back frames: after STOP, one IDLE cycle, then the next pop if data is queued. The inter-frame gap is under one Tick period.
- Tick asserted on the pop cycle is not counted.
- TxEn: deasserting mid-frame has no effect on that frame. Reasserting it resumes popping.
- NBits and WrData changes mid-frame do not affect the frame in flight.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - OVS_DEF=16;
  - NBITS_MIN=5 and NBITS_MAX=8;
  - BAUD_9600_50M=16'd325.
- Sub-module uart_sync_fifo (DEPTH, DATA_W): synchronous FIFO with registered Full, Empty and count. It is reused by future receive buffering.
- The top of this block contains the FSM, counters and shift register.

Test Plan:
- Reset then idle, Tick running, no writes -> Tx=1, Empty=1, TxBusy=0 for 200 Tick periods.
- Write 8'h61, NBits=8 -> Tx pattern 0,1,0,0,0,0,1,1,0,1. Each bit is exactly 16 Ticks (start bit 16–17). TxDone is a single pulse at the end of the stop bit; Empty=1 afterwards.
- Burst of 9 writes (8'h00..8'h08) in consecutive cycles, DEPTH=8 -> the first pop frees a slot so all 9 are accepted. A 10th write while Full -> Overflow pulse, byte lost. Bytes appear on Tx in order 00..08 with a gap under one Tick period between frames.
- NBits=5, write 8'hFF -> frame of start + 5 ones + stop, 7 bits total. NBits=4'd0 -> 8 data bits sent.
- TxEn=0 with 3 bytes queued -> Tx stays 1 and TxBusy=0. Raise TxEn -> 3 frames are sent. Drop TxEn mid-frame -> that frame completes and no further frames start.
- Rst pulse during DATA of byte 8'hA5 with 2 queued -> Tx=1 on the next edge, Empty=1, no TxDone. A fresh write of 8'h3C afterwards is sent correctly.
